// File: rtl/uart_rx.sv
// AXI4-Stream UART receiver, LSB first, bit period = prescale*8 clk cycles.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error,
    input  logic [15:0]           prescale
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  rx_meta;
    logic                  rxs;
    logic [15:0]           p_reg;
    logic [15:0]           p_in;
    logic [18:0]           period;
    logic [18:0]           count;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  tick;
    logic                  par_bad;

    assign p_in   = (prescale == 16'd0) ? 16'd1 : prescale;
    assign period = {p_reg, 3'b000};
    assign tick   = (count == 19'd0);
    assign busy   = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    // Even parity: data bits plus the received parity bit must XOR to zero.
    assign par_bad = ^{shift, par_bit};
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rxs) state_next = START;
            end
            START: begin
                if (tick) state_next = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (tick && bit_cnt == 4'd1) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                if (tick) state_next = rxs ? IDLE : BREAK;
            end
            BREAK: begin
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: synchroniser, bit timing, shifting and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rxs           <= 1'b1;
            p_reg         <= 16'd0;
            count         <= 19'd0;
            bit_cnt       <= 4'd0;
            shift         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
`endif
        end else begin
            rx_meta       <= rxd;
            rxs           <= rx_meta;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;

            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            if (state != IDLE && !tick) count <= count - 19'd1;

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        p_reg <= p_in;
                        count <= {1'b0, p_in, 2'b00} - 19'd1;
                    end
                end
                START: begin
                    if (tick) begin
                        count   <= period - 19'd1;
                        bit_cnt <= 4'(DATA_WIDTH);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift   <= {rxs, shift[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt - 4'd1;
                        count   <= period - 19'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bit <= rxs;
                        count   <= period - 19'd1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        parity_error <= par_bad;
                        if (!rxs) begin
                            frame_error <= 1'b1;
                        end else if (!par_bad) begin
                            // A later load wins over the acceptance clear above.
                            m_axis_tdata  <= shift;
                            m_axis_tvalid <= 1'b1;
                            overrun_error <= m_axis_tvalid && !m_axis_tready;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven on rxd, expected words are
// queued at drive time and checked when the DUT hands them over.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;
    logic        parity_error;
    logic [15:0] prescale;

    int checks = 0;
    int failures = 0;
    int word_cnt = 0;
    int valid_cycles = 0;
    int busy_cycles = 0;
    int ovr_cnt = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] sb[$];

`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int t);
        rxd = b;
        repeat (t) tick();
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                  input logic par_flip, input logic expect_word);
        int t;
        t = 8 * ((prescale == 16'd0) ? 1 : int'(prescale));
        if (expect_word) sb.push_back(data);
        drive_bit(1'b0, t);
        for (int i = 0; i < 8; i++) drive_bit(data[i], t);
`ifdef UART_RX_PARITY_EN
        drive_bit((^data) ^ par_flip, t);
`endif
        drive_bit(stop_bit, t);
        rxd = 1'b1;
    endtask

    // Passive monitor on the falling edge, where inputs driven after the
    // rising edge already hold the values the next rising edge will see.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                check_output("word_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) check_output("tdata", m_axis_tdata, sb.pop_front());
                word_cnt++;
            end
            if (m_axis_tvalid) valid_cycles++;
            if (busy) busy_cycles++;
            if (overrun_error) ovr_cnt++;
            if (frame_error) fe_cnt++;
            if (parity_error) pe_cnt++;
        end
    end

    initial begin
        int w0, v0, b0, o0, f0, p0;
        rst = 1'b1;
        rxd = 1'b1;
        m_axis_tready = 1'b1;
        prescale = 16'd1;
        repeat (3) tick();
        check_output("rst_tdata", m_axis_tdata, 0);
        check_output("rst_tvalid", m_axis_tvalid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_errors", {overrun_error, frame_error, parity_error}, 0);
        rst = 1'b0;
        repeat (5) tick();

        // Plain frame, single-cycle tvalid, busy window length.
        w0 = word_cnt; v0 = valid_cycles; b0 = busy_cycles;
        o0 = ovr_cnt; f0 = fe_cnt; p0 = pe_cnt;
        apply_stimulus(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (16) tick();
        check_output("a5_words", word_cnt - w0, 1);
        check_output("a5_valid_cycles", valid_cycles - v0, 1);
        check_output("a5_busy_cycles", busy_cycles - b0, 4 + (8 + 1 + PAR_BITS) * 8);
        check_output("a5_errors", (ovr_cnt - o0) + (fe_cnt - f0) + (pe_cnt - p0), 0);
        check_output("a5_idle_busy", busy, 0);

        // Back-to-back frames with no acceptance: overrun keeps the newest word.
        prescale = 16'd2;
        m_axis_tready = 1'b0;
        w0 = word_cnt; o0 = ovr_cnt;
        apply_stimulus(8'h11, 1'b1, 1'b0, 1'b0);
        apply_stimulus(8'h22, 1'b1, 1'b0, 1'b1);
        repeat (32) tick();
        check_output("ovr_pulses", ovr_cnt - o0, 1);
        check_output("ovr_tvalid", m_axis_tvalid, 1);
        check_output("ovr_tdata", m_axis_tdata, 8'h22);
        m_axis_tready = 1'b1;
        repeat (4) tick();
        check_output("ovr_words", word_cnt - w0, 1);
        check_output("ovr_tvalid_clear", m_axis_tvalid, 0);

        // Short low glitch is a false start.
        prescale = 16'd1;
        w0 = word_cnt; b0 = busy_cycles; f0 = fe_cnt; p0 = pe_cnt; o0 = ovr_cnt;
        drive_bit(1'b0, 3);
        rxd = 1'b1;
        repeat (20) tick();
        check_output("glitch_busy_cycles", busy_cycles - b0, 4);
        check_output("glitch_busy", busy, 0);
        check_output("glitch_words", word_cnt - w0, 0);
        check_output("glitch_errors", (ovr_cnt - o0) + (fe_cnt - f0) + (pe_cnt - p0), 0);

        // Bad stop bit followed by a held break, then recovery.
        w0 = word_cnt; f0 = fe_cnt;
        apply_stimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 40);
        rxd = 1'b1;
        repeat (20) tick();
        check_output("break_fe_pulses", fe_cnt - f0, 1);
        check_output("break_words", word_cnt - w0, 0);
        apply_stimulus(8'h5A, 1'b1, 1'b0, 1'b1);
        repeat (16) tick();
        check_output("after_break_words", word_cnt - w0, 1);

        // Reset in the middle of the data bits abandons the frame.
        w0 = word_cnt; f0 = fe_cnt;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 24);
        rst = 1'b1;
        tick();
        check_output("midrst_tdata", m_axis_tdata, 0);
        check_output("midrst_tvalid", m_axis_tvalid, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_errors", {overrun_error, frame_error, parity_error}, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (60) tick();
        apply_stimulus(8'h81, 1'b1, 1'b0, 1'b1);
        repeat (16) tick();
        check_output("midrst_words", word_cnt - w0, 1);
        check_output("midrst_fe", fe_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
        w0 = word_cnt; p0 = pe_cnt;
        apply_stimulus(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (16) tick();
        check_output("par_ok_words", word_cnt - w0, 1);
        check_output("par_ok_pe", pe_cnt - p0, 0);
        w0 = word_cnt;
        apply_stimulus(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (16) tick();
        check_output("par_bad_pe", pe_cnt - p0, 1);
        check_output("par_bad_words", word_cnt - w0, 0);
`endif

        check_output("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- AXI4-Stream UART receiver; the receive-side counterpart to the team's uart_tx.
- Deserialises an asynchronous 8N1 (default) serial line `rxd` into parallel words presented on an AXI4-Stream master interface.
- Shares uart_tx's prescale convention: bit period = prescale*8 clk cycles, so both ends of a link are configured identically.
- Reports busy, overrun and framing status for the UART wrapper/status registers.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, LSB first; legal range 5..9.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- m_axis_tdata  output  DATA_WIDTH  received word.
- m_axis_tvalid  output  1  received word valid.
- m_axis_tready  input  1  downstream accepts word.
- rxd  input  1  asynchronous serial input, idle high.
- busy  output  1  frame reception in progress.
- overrun_error  output  1  one-cycle pulse: new word completed while previous word still unaccepted.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- parity_error  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN).
- prescale  input  16  clk cycles per bit divided by 8.

Behaviour:
- Reset: m_axis_tdata=0, m_axis_tvalid=0, busy=0, all error outputs 0, synchroniser flops=1, FSM=IDLE, counters=0. Reset mid-frame abandons the frame with no output and no error.
- `rxd` passes through a 2-flop synchroniser (both flops reset to 1); all decisions use the synchronised value rxs. Pin-to-rxs latency is 2 cycles.
- `prescale` is captured at start detection and held for the whole frame; changes mid-frame have no effect. prescale=0 is treated as 1.
- Bit period T = P*8, where P is the captured prescale; computed in 19 bits with no overflow.
- IDLE:
  - busy=0.
  - On rxs==0: load counter=P*4-1 (half-bit), busy=1, go to START.
- START:
  - Counter decrements once per cycle; the sample is taken on the cycle the counter is 0.
  - If rxs==1 at the sample: false start; go to IDLE, busy=0, no error.
  - Else: counter=T-1, bit_cnt=DATA_WIDTH, go to DATA.
- DATA:
  - At each counter==0, shift rxs into the MSB of the shift register (LSB-first reception) and reload counter=T-1.
  - After DATA_WIDTH samples go to PARITY (macro on) or STOP (macro off).
- STOP, at counter==0:
  - rxs==1: m_axis_tdata<=shift register and m_axis_tvalid<=1 in the cycle after the sample; go to IDLE; busy drops the same cycle.
  - rxs==0: frame_error pulses 1 cycle, the word is discarded, and the FSM goes to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. A held-low line (break) therefore yields exactly one frame_error.
- Handshake:
  - m_axis_tvalid clears on the cycle after tvalid&&tready.
  - tdata is stable while tvalid=1 and unaccepted, except under overrun.
- Overrun: a new word completes while tvalid=1 and tready=0 in the same cycle, so the new word overwrites tdata, tvalid stays 1 and overrun_error pulses 1 cycle. If tready=1 in that cycle, the old word is accepted, the new word loads, and there is no error.
- Reception never stalls on tready; the line is never back-pressured.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA, sampling one bit after T cycles; even parity over data bits plus the parity bit.
  - Mismatch: parity_error pulses 1 cycle at the stop-bit sample, the word is discarded, and the FSM still checks the stop bit (frame_error may pulse the same cycle).
  - Frame length becomes DATA_WIDTH+3 bits.
- Undefined: no PARITY state, frame 8N1 (DATA_WIDTH+2 bits), parity_error constant 0.

Test Plan:
- prescale=1 (T=8), tready=1, send 0xA5 8N1 -> tvalid=1 with tdata=0xA5 for exactly 1 cycle; busy high from start detect to stop sample; no errors.
- prescale=2, tready=0, send 0x11 then 0x22 back-to-back -> after the second frame tdata=0x22, overrun_error pulses once, tvalid stays 1 until tready.
- prescale=1, rxd low for 3 cycles then high (glitch) -> false start, busy pulses then returns 0; tvalid and errors stay 0.
- prescale=1, send 0x3C with stop bit 0, then hold rxd low for 40 cycles -> frame_error pulses exactly once, no tvalid; the next valid frame 0x5A is received correctly.
- Assert rst mid-DATA of frame 0xFF, release, then send 0x81 -> no output from the aborted frame; tdata=0x81 received; all outputs at reset values during rst.
- UART_RX_PARITY_EN: send 0x07 with parity 1 -> tdata=0x07; send 0x07 with parity 0 -> parity_error pulse, no tvalid.
